// File: rtl/ram_pattern_checker.sv
`timescale 1ns/1ps
// ram_pattern_checker
// Traffic source and sink for the bit-serial RAM shifter used in the xc7 memory tests.
// The block sends one pattern word per RAM frame into the shifter's parallel input.
// It checks each word that comes back against the word it sent LATENCY_FRAMES frames earlier.
// A frame tick is a clock edge where rst is low and addr is 0. Apart from reset, state changes only on tick edges.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   addr           shifter address; addr == 0 marks the frame tick
//   word_in        returned word from the shifter's parallel output
//   word_out       pattern word driven to the shifter's parallel input
//   pass           sticky: PASS_FRAMES consecutive good compares, no error since reset
//   error          sticky: at least one mismatch since reset
//   error_count    mismatching compares, saturating at 255
//   frame_count    frame ticks since reset, wrapping at 2**16
//   dbg_state      FSM state (0 WARMUP, 1 CHECK, 2 PASSED, 3 FAILED)
//
// Optional build macro RAM_PATTERN_CHECKER_CAPTURE_EN adds two ports:
//   first_expected / first_received  expected and received words of the first mismatch after reset
module ram_pattern_checker #(
  parameter int          IO_WIDTH       = 16,
  parameter int          ADDR_WIDTH     = 4,
  parameter int          LATENCY_FRAMES = 2,
  parameter logic [15:0] SEED           = 16'h0001,
  parameter logic [15:0] INCR           = 16'h9E37,
  parameter int          PASS_FRAMES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [IO_WIDTH-1:0]   word_in,
  output logic [IO_WIDTH-1:0]   word_out,
  output logic                  pass,
  output logic                  error,
  output logic [7:0]            error_count,
  output logic [15:0]           frame_count,
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
  output logic [IO_WIDTH-1:0]   first_expected,
  output logic [IO_WIDTH-1:0]   first_received,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_CHECK  = 2'd1,
    S_PASSED = 2'd2,
    S_FAILED = 2'd3
  } state_t;

  localparam int GW = $clog2(PASS_FRAMES + 1);
  localparam logic [IO_WIDTH-1:0] SEED_W = IO_WIDTH'(SEED);
  localparam logic [IO_WIDTH-1:0] INCR_W = IO_WIDTH'(INCR);
  localparam logic [GW-1:0]       PASS_W = GW'(PASS_FRAMES);

  state_t                    state_q;
  logic [IO_WIDTH-1:0]       word_q;
  logic [IO_WIDTH-1:0]       hist_q [LATENCY_FRAMES];
  logic [LATENCY_FRAMES-1:0] hist_v_q;
  logic [LATENCY_FRAMES-1:0] hist_v_d;
  logic [GW-1:0]             good_q;
  logic [GW-1:0]             good_d;
  logic                      pass_q;
  logic                      error_q;
  logic [7:0]                err_cnt_q;
  logic [15:0]               frame_q;
  logic                      tick;
  logic                      do_cmp;
  logic                      mismatch;
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
  logic [IO_WIDTH-1:0]       first_exp_q;
  logic [IO_WIDTH-1:0]       first_rcv_q;
`endif

  assign tick = !rst && (addr == '0);

  always_comb begin
    // Valid bits as they will be after this tick's push.
    // WARMUP exits on the tick that makes the oldest entry valid.
    hist_v_d    = hist_v_q;
    hist_v_d[0] = 1'b1;
    for (int i = 1; i < LATENCY_FRAMES; i++) begin
      hist_v_d[i] = hist_v_q[i-1];
    end
    do_cmp   = hist_v_q[LATENCY_FRAMES-1] && (state_q != S_WARMUP);
    mismatch = do_cmp && (word_in != hist_q[LATENCY_FRAMES-1]);
    good_d   = good_q;
    if (do_cmp) begin
      if (mismatch) begin
        good_d = '0;
      end else if (good_q != PASS_W) begin
        good_d = good_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WARMUP;
      word_q    <= SEED_W;
      hist_v_q  <= '0;
      good_q    <= '0;
      pass_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      frame_q   <= '0;
      for (int i = 0; i < LATENCY_FRAMES; i++) begin
        hist_q[i] <= '0;
      end
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
      first_exp_q <= '0;
      first_rcv_q <= '0;
`endif
    end else if (tick) begin
      // The shifter samples the word before this update at the same edge, so that word is also the one recorded in history.
      word_q    <= word_q + INCR_W;
      hist_q[0] <= word_q;
      for (int i = 1; i < LATENCY_FRAMES; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      hist_v_q <= hist_v_d;
      frame_q  <= frame_q + 16'd1;
      good_q   <= good_d;

      case (state_q)
        S_WARMUP: if (hist_v_d[LATENCY_FRAMES-1]) state_q <= S_CHECK;
        S_CHECK: begin
          if (mismatch) begin
            state_q <= S_FAILED;
          end else if (good_d == PASS_W && !error_q) begin
            state_q <= S_PASSED;
            pass_q  <= 1'b1;
          end
        end
        S_PASSED: if (mismatch) state_q <= S_FAILED;
        default: ;
      endcase

      if (mismatch) begin
        error_q <= 1'b1;
        pass_q  <= 1'b0;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
        if (!error_q) begin
          first_exp_q <= hist_q[LATENCY_FRAMES-1];
          first_rcv_q <= word_in;
        end
`endif
      end
    end
  end

  assign word_out    = word_q;
  assign pass        = pass_q;
  assign error       = error_q;
  assign error_count = err_cnt_q;
  assign frame_count = frame_q;
  assign dbg_state   = state_q;
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
  assign first_expected = first_exp_q;
  assign first_received = first_rcv_q;
`endif

endmodule

// File: tb/tb_ram_pattern_checker.sv
`timescale 1ns/1ps
// Testbench for ram_pattern_checker.
// The bench drives addr as a free-running frame counter and loops the pattern back with a configurable delay in ticks.
// It can flip bits in the returned word on one chosen tick.
// On each tick, a reference model pushes the expected post-tick outputs into exp_q.
// The monitor process pops exp_q and compares on every tick edge.
module tb_ram_pattern_checker;
  localparam int          LAT  = 2;
  localparam int          PF   = 16;
  localparam logic [15:0] SEED = 16'h0001;
  localparam logic [15:0] INCR = 16'h9E37;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = 4'd0;
  logic [15:0] word_in = 16'h0000;
  logic [15:0] word_out;
  logic        pass;
  logic        error;
  logic [7:0]  error_count;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
  logic [15:0] first_expected;
  logic [15:0] first_received;
`endif

  always #5 clk = ~clk;

  ram_pattern_checker dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .word_in        (word_in),
    .word_out       (word_out),
    .pass           (pass),
    .error          (error),
    .error_count    (error_count),
    .frame_count    (frame_count),
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
    .first_expected (first_expected),
    .first_received (first_received),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] word;
    logic        pass;
    logic        error;
    logic [7:0]  ecnt;
    logic [15:0] frame;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_word;
  logic [15:0] m_frame;
  logic [15:0] m_fe;
  logic [15:0] m_fr;
  logic [1:0]  m_st;
  logic        m_error;
  logic        m_pass;
  int          m_tick;
  int          m_good;
  int          m_ecnt;
  logic [15:0] sent[$];
  int          lb_delay = 2;
  int          flip_tick = -1;
  logic [15:0] flip_mask = 16'h0008;
  int          a_cnt = 0;
  int          ticks_driven = 0;

  task automatic model_reset();
    m_word = SEED; m_frame = 16'h0; m_st = 2'd0; m_error = 1'b0; m_pass = 1'b0;
    m_tick = 0; m_good = 0; m_ecnt = 0; m_fe = 16'h0; m_fr = 16'h0;
    sent.delete();
  endtask

  task automatic model_tick(output logic [15:0] win);
    int          t;
    logic [15:0] e;
    exp_t        x;
    t = m_tick + 1;
    // word sent at tick t-lb_delay returns now; sent[k] was sampled at tick k+1
    if (t - 1 - lb_delay >= 0) win = sent[t - 1 - lb_delay];
    else win = 16'hFFFF;
    if (t == flip_tick) win = win ^ flip_mask;
    if (t > LAT) begin
      e = sent[t - 1 - LAT];
      if (win == e) begin
        m_good = (m_good < PF) ? m_good + 1 : PF;
      end else begin
        if (!m_error) begin m_fe = e; m_fr = win; end
        m_error = 1'b1;
        m_ecnt  = (m_ecnt < 255) ? m_ecnt + 1 : 255;
        m_good  = 0;
        m_pass  = 1'b0;
      end
    end
    if (t < LAT) m_st = 2'd0;
    else if (t == LAT) m_st = 2'd1;
    else if (m_error) m_st = 2'd3;
    else if (m_st == 2'd2 || m_good == PF) begin m_st = 2'd2; m_pass = 1'b1; end
    else m_st = 2'd1;
    sent.push_back(m_word);
    m_word  = m_word + INCR;
    m_frame = m_frame + 16'd1;
    m_tick  = t;
    x.word = m_word; x.pass = m_pass; x.error = m_error; x.ecnt = m_ecnt[7:0];
    x.frame = m_frame; x.st = m_st;
    exp_q.push_back(x);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cur();
    logic [15:0] w;
    addr = a_cnt[3:0];
    if (a_cnt == 0) begin
      model_tick(w);
      word_in = w;
      ticks_driven++;
    end
    a_cnt = (a_cnt + 1) % 16;
  endtask

  task automatic step();
    @(negedge clk);
    drive_cur();
  endtask

  // runs until n more ticks have been applied, then settles just after that tick edge
  task automatic run_ticks(input int n);
    int target;
    target = ticks_driven + n;
    while (ticks_driven < target) step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int a);
    @(negedge clk);
    rst  = 1'b1;
    addr = a[3:0];
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_word_out", word_out, 16'h0001);
    chk("rst_pass", pass, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_error_count", error_count, 8'd0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_state", dbg_state, 2'd0);
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
    chk("rst_first_expected", first_expected, 16'h0);
    chk("rst_first_received", first_received, 16'h0);
`endif
    a_cnt = (a + 1) % 16;
    drive_cur();
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    if (!rst && addr == 4'd0) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tick_no_expected: tick seen with empty queue (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tick_word_out", word_out, mon_e.word);
        chk("tick_pass", pass, mon_e.pass);
        chk("tick_error", error, mon_e.error);
        chk("tick_error_count", error_count, mon_e.ecnt);
        chk("tick_frame_count", frame_count, mon_e.frame);
        chk("tick_state", dbg_state, mon_e.st);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // ideal loopback, 20 frames
    do_reset(0);
    lb_delay = 2; flip_tick = -1;
    run_ticks(1);  chk("word_tick1", word_out, 16'h9E38);
    run_ticks(1);  chk("word_tick2", word_out, 16'h3C6F);
    chk("state_checking_tick2", dbg_state, 2'd1);
    run_ticks(15); chk("pass_tick17", pass, 1'b0);
    run_ticks(1);  chk("pass_tick18", pass, 1'b1);
    chk("state_passed_tick18", dbg_state, 2'd2);
    run_ticks(2);
    chk("frame_count_20", frame_count, 16'd20);
    chk("error_clean", error, 1'b0);
    chk("error_count_clean", error_count, 8'd0);

    // reset while addr == 0 (reset beats tick), then bit-3 flip on tick 10
    do_reset(0);
    flip_tick = 10;
    run_ticks(9);  chk("error_before_flip", error, 1'b0);
    run_ticks(1);
    chk("error_at_flip", error, 1'b1);
    chk("error_count_at_flip", error_count, 8'd1);
    chk("state_failed", dbg_state, 2'd3);
    run_ticks(10);
    chk("pass_after_flip", pass, 1'b0);
    chk("error_count_after_flip", error_count, 8'd1);
`ifdef RAM_PATTERN_CHECKER_CAPTURE_EN
    chk("capture_diff_bit3", first_expected ^ first_received, 16'h0008);
    chk("capture_expected", first_expected, m_fe);
    chk("capture_received", first_received, m_fr);
`endif

    // hold addr at 5 for 100 cycles: nothing may move
    repeat (100) begin
      @(negedge clk);
      addr = 4'd5;
    end
    @(posedge clk);
    #2;
    chk("hold_word_out", word_out, m_word);
    chk("hold_frame_count", frame_count, m_frame);
    chk("hold_error", error, m_error);
    chk("hold_error_count", error_count, m_ecnt[7:0]);
    chk("hold_state", dbg_state, m_st);
    a_cnt = 6;

    // reset mid-frame at addr 7 after failure, then recover with good loopback
    while (a_cnt != 7) step();
    flip_tick = -1;
    do_reset(7);
    run_ticks(17); chk("recover_pass_tick17", pass, 1'b0);
    run_ticks(1);  chk("recover_pass_tick18", pass, 1'b1);

    // loopback one tick too slow: every compare fails, counter saturates
    do_reset(3);
    lb_delay = 3;
    run_ticks(256); chk("ecnt_254", error_count, 8'd254);
    run_ticks(1);   chk("ecnt_255", error_count, 8'd255);
    run_ticks(5);   chk("ecnt_saturated", error_count, 8'd255);
    chk("slow_pass", pass, 1'b0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
